// File: rtl/lsu_rmw_if.sv
// Core-request and RAM data-port bundle for lsu_rmw; slave is the LSU side, master the core/RAM side.
interface lsu_rmw_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_data_i,
    output busy_o, done_o, rdata_o, err_o, ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_data_i,
    input  busy_o, done_o, rdata_o, err_o, ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/lsu_rmw.sv
// Big-endian load/store unit doing read-modify-write for sub-word stores; load/word store 2 cycles, sub-word store 3.
// Requests are ignored while busy (no queuing); LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into err_o traps.
module lsu_rmw #(
  parameter int RAM_ADDR_WIDTH = 12
) (
  input logic      clk_i,
  input logic      rst_i,
  lsu_rmw_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;
  state_e state_q, state_d;

  logic                      we_q, uns_q, err_q;
  logic [1:0]                size_q, off_q;
  logic [RAM_ADDR_WIDTH-1:2] widx_q;
  logic [31:0]               wdata_q, rword_q, rdata_q;

  logic        accept, misalign;
  logic [1:0]  off_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val, merged, word_addr;
  logic        ram_we_raw;
  logic [31:0] ram_addr, ram_data;
  logic        unused_addr_hi;

  assign accept         = (state_q == IDLE) && bus.req_i;
  assign unused_addr_hi = ^bus.addr_i[31:RAM_ADDR_WIDTH];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                    (bus.size_i[1] && (bus.addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Effective lane offset: sub-size low address bits are dropped when not trapping.
  always_comb begin
    off_d = 2'b00;
    unique case (bus.size_i)
      2'b00:   off_d = bus.addr_i[1:0];
      2'b01:   off_d = {bus.addr_i[1], 1'b0};
      default: off_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (misalign)                       state_d = DONE;
          else if (bus.we_i && bus.size_i[1]) state_d = WR;
          else                                state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.we_i;
        size_q  <= bus.size_i;
        uns_q   <= bus.unsigned_i;
        widx_q  <= bus.addr_i[RAM_ADDR_WIDTH-1:2];
        off_q   <= off_d;
        wdata_q <= bus.wdata_i;
        err_q   <= misalign;
        if (misalign) rdata_q <= '0;
      end
      if (state_q == RD) begin
        rword_q <= bus.ram_data_i;
        if (!we_q) rdata_q <= load_val;
      end
    end
  end

  // Lane 0 is the most significant byte.
  always_comb begin
    lane_b = bus.ram_data_i[31:24];
    unique case (off_q)
      2'd0:    lane_b = bus.ram_data_i[31:24];
      2'd1:    lane_b = bus.ram_data_i[23:16];
      2'd2:    lane_b = bus.ram_data_i[15:8];
      default: lane_b = bus.ram_data_i[7:0];
    endcase
    lane_h = off_q[1] ? bus.ram_data_i[15:0] : bus.ram_data_i[31:16];
    load_val = bus.ram_data_i;
    unique case (size_q)
      2'b00:   load_val = {{24{lane_b[7] & ~uns_q}}, lane_b};
      2'b01:   load_val = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_val = bus.ram_data_i;
    endcase
  end

  always_comb begin
    merged = rword_q;
    unique case (size_q)
      2'b00: begin
        unique case (off_q)
          2'd0:    merged[31:24] = wdata_q[7:0];
          2'd1:    merged[23:16] = wdata_q[7:0];
          2'd2:    merged[15:8]  = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (off_q[1]) merged[15:0]  = wdata_q[15:0];
        else          merged[31:16] = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    word_addr                     = '0;
    word_addr[RAM_ADDR_WIDTH-1:2] = widx_q;
  end

  always_comb begin
    ram_we_raw = 1'b0;
    ram_addr   = '0;
    ram_data   = '0;
    unique case (state_q)
      RD: ram_addr = word_addr;
      WR: begin
        ram_we_raw = 1'b1;
        ram_addr   = word_addr;
        ram_data   = merged;
      end
      default: ;
    endcase
  end

  assign bus.busy_o     = (state_q != IDLE);
  assign bus.done_o     = (state_q == DONE);
  assign bus.rdata_o    = rdata_q;
  assign bus.err_o      = err_q;
  assign bus.ram_we_o   = ram_we_raw & ~rst_i;
  assign bus.ram_addr_o = ram_addr;
  assign bus.ram_data_o = ram_data;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed and random checks of lsu_rmw against a byte-level memory model and a word-array RAM.
module tb_lsu_rmw;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_rmw_if bus();
  lsu_rmw #(.RAM_ADDR_WIDTH(12)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  logic [31:0] mem [1024];
  bit   [31:0] ref_mem [1024];
  logic [31:0] exp_rdata;
  int wr_cnt = 0;
  int n_chk  = 0;
  int n_fail = 0;

  assign bus.ram_data_i = mem[bus.ram_addr_o[11:2]];

  always @(posedge clk) begin
    if (bus.ram_we_o === 1'b1) begin
      mem[bus.ram_addr_o[11:2]] = bus.ram_data_o;
      wr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit [31:0] a, input bit [31:0] v);
    mem[a[11:2]]     = v;
    ref_mem[a[11:2]] = v;
  endtask

  task automatic drive(input bit we, input bit [1:0] sz, input bit uns, input bit [31:0] a, input bit [31:0] wd);
    bus.we_i       = we;
    bus.size_i     = sz;
    bus.unsigned_i = uns;
    bus.addr_i     = a;
    bus.wdata_i    = wd;
  endtask

  // Reference: byte-addressed big-endian memory semantics, expressed arithmetically.
  function automatic void model_op(input bit we, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                                   input bit [31:0] wd, output int lat, output bit err, output int nwr,
                                   output bit [31:0] ram_a);
    int nb, o, wi, sh;
    longint unsigned mask, v;
    bit [31:0] b;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    wi  = int'((a % 4096) / 4);
    o   = int'(a % 4);
    err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (o % nb != 0) begin
      err = 1'b1; lat = 1; nwr = 0; ram_a = 0; exp_rdata = 0;
      return;
    end
`endif
    o     = o - (o % nb);
    ram_a = (a % 4096) - (a % 4);
    mask  = (64'd1 << (8 * nb)) - 1;
    if (!we) begin
      v = (64'(ref_mem[wi]) >> (8 * (4 - o - nb))) & mask;
      if (!uns && v[8 * nb - 1]) v = v | ~mask;
      exp_rdata = v[31:0];
      lat = 2;
      nwr = 0;
    end else begin
      for (int k = 0; k < nb; k++) begin
        sh = 8 * (3 - (o + k));
        b  = (wd >> (8 * (nb - 1 - k))) & 32'hFF;
        ref_mem[wi] = (ref_mem[wi] & ~(32'hFF << sh)) | (b << sh);
      end
      lat = (nb == 4) ? 2 : 3;
      nwr = 1;
    end
  endfunction

  task automatic do_op(input string tag, input bit we, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd);
    int lat_e, nwr_e, lat, wr0, wi;
    bit err_e;
    bit [31:0] ra_e;
    model_op(we, sz, uns, a, wd, lat_e, err_e, nwr_e, ra_e);
    wi  = int'(a[11:2]);
    wr0 = wr_cnt;
    drive(we, sz, uns, a, wd);
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    chk({tag, " busy"}, 32'(bus.busy_o), 32'd1);
    chk({tag, " ram_addr"}, bus.ram_addr_o, ra_e);
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    chk({tag, " latency"}, lat, lat_e);
    chk({tag, " err"}, 32'(bus.err_o), 32'(err_e));
    chk({tag, " rdata"}, bus.rdata_o, exp_rdata);
    chk({tag, " writes"}, wr_cnt - wr0, nwr_e);
    chk({tag, " mem"}, mem[wi], ref_mem[wi]);
    step();
    chk({tag, " done_pulse"}, 32'(bus.done_o), 32'd0);
    chk({tag, " idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int lat_e, nwr_e, wr0;
    bit err_e;
    bit [31:0] ra_e;

    rst = 1'b1;
    bus.req_i = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) preload(32'(i * 4), $urandom);
    exp_rdata = '0;
    step();
    step();
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst rdata", bus.rdata_o, 32'd0);
    chk("rst err", 32'(bus.err_o), 32'd0);
    chk("rst ram_we", 32'(bus.ram_we_o), 32'd0);
    chk("rst ram_addr", bus.ram_addr_o, 32'd0);
    chk("rst ram_data", bus.ram_data_o, 32'd0);
    rst = 1'b0;
    step();

    preload(32'h10, 32'h11223344);
    do_op("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("ld_byte_s value", bus.rdata_o, 32'h00000022);

    preload(32'h20, 32'h80FF0000);
    do_op("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    chk("ld_half_s value", bus.rdata_o, 32'hFFFF80FF);
    do_op("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("ld_half_u value", bus.rdata_o, 32'h000080FF);

    do_op("st_byte", 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000AB);
    chk("st_byte word", mem[4], 32'h112233AB);
    chk("st_byte rdata kept", bus.rdata_o, 32'h000080FF);

    // Word store with req_i held high, then a load accepted right after DONE.
    model_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat_e, err_e, nwr_e, ra_e);
    wr0 = wr_cnt;
    drive(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    bus.req_i = 1'b1;
    step();
    chk("hold busy", 32'(bus.busy_o), 32'd1);
    step();
    chk("hold done@2", 32'(bus.done_o), 32'd1);
    chk("hold one write", wr_cnt - wr0, 32'd1);
    model_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat_e, err_e, nwr_e, ra_e);
    bus.we_i = 1'b0;
    step();
    chk("b2b idle", 32'(bus.busy_o), 32'd0);
    step();
    chk("b2b accepted", 32'(bus.busy_o), 32'd1);
    bus.req_i = 1'b0;
    step();
    chk("b2b done", 32'(bus.done_o), 32'd1);
    chk("b2b rdata", bus.rdata_o, 32'hDEADBEEF);
    chk("b2b still one write", wr_cnt - wr0, 32'd1);
    chk("b2b mem", mem[16], ref_mem[16]);
    step();

    // Reset while the sub-word store sits in WR.
    wr0 = wr_cnt;
    drive(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
    bus.req_i = 1'b1;
    step();
    bus.req_i = 1'b0;
    step();
    chk("abort in WR", 32'(bus.ram_we_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort we gated", 32'(bus.ram_we_o), 32'd0);
    step();
    rst = 1'b0;
    exp_rdata = '0;
    #1;
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort done", 32'(bus.done_o), 32'd0);
    chk("abort rdata", bus.rdata_o, 32'd0);
    chk("abort ram_addr", bus.ram_addr_o, 32'd0);
    chk("abort ram_data", bus.ram_data_o, 32'd0);
    chk("abort no write", wr_cnt - wr0, 32'd0);
    chk("abort mem", mem[4], ref_mem[4]);
    step();
    chk("abort no done", 32'(bus.done_o), 32'd0);

    preload(32'h10, 32'hCAFEF00D);
    do_op("ld_word_mis", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("ld_word_mis value", bus.rdata_o, 32'h0);
`else
    chk("ld_word_mis value", bus.rdata_o, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 60; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_F03F, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
